// File: rtl/piece_sprite_fetch.sv
// Board-square lookup and piece-sprite fetch for the pixel pipeline; 3-cycle latency.
// Optional `BOARD_FLIP_EN adds a `flip` input that rotates the board view by 180 degrees.
module piece_sprite_fetch #(
    parameter int BOARD_X0 = 80,
    parameter int BOARD_Y0 = 0,
    parameter int SQ_SIZE  = 60,
    parameter int ROM_AW   = 16
) (
    input  logic              Clk,
    input  logic              Reset,
`ifdef BOARD_FLIP_EN
    input  logic              flip,
`endif
    input  logic              pix_valid,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [5:0]        board_addr,
    input  logic [3:0]        board_data,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic              pix_valid_out,
    output logic [3:0]        pal_index,
    output logic              piece_present,
    output logic              square_light,
    output logic              in_board
);

    // Stage 0 (combinational)
    logic [10:0] x_rel, y_rel, x_off, y_off;
    logic [2:0]  col, row;
    logic [5:0]  x_in0, y_in0, sq_idx;
    logic        in_board0, flip0;

    // Pipeline registers
    logic       s1_valid_d, s1_valid_q, s1_in_board_d, s1_in_board_q, s1_light_d, s1_light_q;
    logic [5:0] s1_x_in_d, s1_x_in_q, s1_y_in_d, s1_y_in_q;
    logic       s2_valid_d, s2_valid_q, s2_in_board_d, s2_in_board_q;
    logic       s2_light_d, s2_light_q, s2_present_d, s2_present_q;
    logic       out_valid_d, out_valid_q, out_in_board_d, out_in_board_q;
    logic       out_light_d, out_light_q, out_present_d, out_present_q;
    logic [3:0] out_pal_d, out_pal_q;

    logic        code_ok;
    logic [31:0] rom_sum;

`ifdef BOARD_FLIP_EN
    assign flip0 = flip;
`else
    assign flip0 = 1'b0;
`endif

    always_comb begin
        // A pixel left/above the board wraps to a large relative value and fails the range test.
        x_rel     = {1'b0, DrawX} - 11'(BOARD_X0);
        y_rel     = {1'b0, DrawY} - 11'(BOARD_Y0);
        in_board0 = (x_rel < 11'(8 * SQ_SIZE)) && (y_rel < 11'(8 * SQ_SIZE));
        col   = '0;
        row   = '0;
        x_off = '0;
        y_off = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (x_rel >= 11'(k * SQ_SIZE)) begin
                col   = col + 3'd1;
                x_off = 11'(k * SQ_SIZE);
            end
            if (y_rel >= 11'(k * SQ_SIZE)) begin
                row   = row + 3'd1;
                y_off = 11'(k * SQ_SIZE);
            end
        end
        x_in0  = 6'(x_rel - x_off);
        y_in0  = 6'(y_rel - y_off);
        sq_idx = {row, col};

        board_addr = '0;
        if (in_board0 && !Reset)
            board_addr = flip0 ? (6'd63 - sq_idx) : sq_idx;
    end

    always_comb begin
        s1_valid_d    = pix_valid;
        s1_in_board_d = pix_valid & in_board0;
        s1_light_d    = pix_valid & in_board0 & ~(row[0] ^ col[0]);
        s1_x_in_d     = x_in0;
        s1_y_in_d     = y_in0;

        // Codes 13..15 are treated as empty squares.
        code_ok = (board_data != 4'd0) && (board_data <= 4'd12);
        rom_sum = '0;
        if (code_ok && s1_in_board_q)
            rom_sum = 32'(board_data - 4'd1) * 32'(SQ_SIZE * SQ_SIZE)
                    + 32'(s1_y_in_q) * 32'(SQ_SIZE) + 32'(s1_x_in_q);
        rom_addr = ROM_AW'(rom_sum);

        s2_valid_d    = s1_valid_q;
        s2_in_board_d = s1_in_board_q;
        s2_light_d    = s1_light_q;
        s2_present_d  = code_ok & s1_in_board_q;

        out_valid_d    = s2_valid_q;
        out_in_board_d = s2_in_board_q;
        out_light_d    = s2_light_q;
        out_present_d  = s2_present_q;
        out_pal_d      = s2_present_q ? rom_data : '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_valid_q     <= 1'b0;
            s1_in_board_q  <= 1'b0;
            s1_light_q     <= 1'b0;
            s1_x_in_q      <= '0;
            s1_y_in_q      <= '0;
            s2_valid_q     <= 1'b0;
            s2_in_board_q  <= 1'b0;
            s2_light_q     <= 1'b0;
            s2_present_q   <= 1'b0;
            out_valid_q    <= 1'b0;
            out_in_board_q <= 1'b0;
            out_light_q    <= 1'b0;
            out_present_q  <= 1'b0;
            out_pal_q      <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_in_board_q  <= s1_in_board_d;
            s1_light_q     <= s1_light_d;
            s1_x_in_q      <= s1_x_in_d;
            s1_y_in_q      <= s1_y_in_d;
            s2_valid_q     <= s2_valid_d;
            s2_in_board_q  <= s2_in_board_d;
            s2_light_q     <= s2_light_d;
            s2_present_q   <= s2_present_d;
            out_valid_q    <= out_valid_d;
            out_in_board_q <= out_in_board_d;
            out_light_q    <= out_light_d;
            out_present_q  <= out_present_d;
            out_pal_q      <= out_pal_d;
        end
    end

    assign pix_valid_out = out_valid_q;
    assign pal_index     = out_pal_q;
    assign piece_present = out_present_q;
    assign square_light  = out_light_q;
    assign in_board      = out_in_board_q;

endmodule

// File: tb/tb_piece_sprite_fetch.sv
// Directed self-checking bench for piece_sprite_fetch with behavioural board RAM and sprite ROM.
module tb_piece_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        pix_valid;
    logic [9:0]  DrawX, DrawY;
    logic [5:0]  board_addr;
    logic [3:0]  board_data = '0;
    logic [15:0] rom_addr;
    logic [3:0]  rom_data = '0;
    logic        pix_valid_out, piece_present, square_light, in_board;
    logic [3:0]  pal_index;
`ifdef BOARD_FLIP_EN
    logic        flip = 1'b0;
`endif

    logic [3:0]  board_mem [64];
    logic [3:0]  rom_const = 4'd7;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  outs;

    piece_sprite_fetch #(.BOARD_X0(80), .BOARD_Y0(0), .SQ_SIZE(60), .ROM_AW(16)) dut (
        .Clk(Clk), .Reset(Reset),
`ifdef BOARD_FLIP_EN
        .flip(flip),
`endif
        .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
        .board_addr(board_addr), .board_data(board_data),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_valid_out(pix_valid_out), .pal_index(pal_index),
        .piece_present(piece_present), .square_light(square_light), .in_board(in_board)
    );

    always #5 Clk = ~Clk;

    // Synchronous memories, 1-cycle latency; ROM content depends on the low address nibble.
    always @(posedge Clk) begin
        board_data <= board_mem[board_addr];
        rom_data   <= rom_const ^ rom_addr[3:0];
    end

    assign outs = {pix_valid_out, pal_index, piece_present, square_light, in_board};

    task automatic put(input logic v, input logic [9:0] x, input logic [9:0] y);
        @(negedge Clk);
        pix_valid = v;
        DrawX = x;
        DrawY = y;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) put(1'b0, 10'd0, 10'd0);
    endtask

    task automatic test_reset();
        Reset = 1'b1; pix_valid = 1'b1; DrawX = 10'd80; DrawY = 10'd0;
        board_mem[0] = 4'd5;
        repeat (3) @(negedge Clk);
        #1;
        n_cmp++;
        if (outs !== 8'h00) begin n_bad++; $display("FAIL reset_outs got %h want 00", outs); end
        n_cmp++;
        if (board_addr !== 6'd0) begin n_bad++; $display("FAIL reset_board_addr got %0d want 0", board_addr); end
        n_cmp++;
        if (rom_addr !== 16'd0) begin n_bad++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge Clk);
            #1;
            n_cmp++;
            if (pix_valid_out !== (i == 3)) begin
                n_bad++;
                $display("FAIL reset_first_valid cyc%0d got %b want %b", i, pix_valid_out, (i == 3));
            end
        end
        pix_valid = 1'b0;
        drain();
    endtask

    task automatic test_corner_square();
        board_mem[0] = 4'd5; rom_const = 4'd7;
        put(1'b1, 10'd80, 10'd0);
        n_cmp++;
        if (board_addr !== 6'd0) begin n_bad++; $display("FAIL corner_board_addr got %0d want 0", board_addr); end
        put(1'b0, 10'd0, 10'd0);
        n_cmp++;
        if (rom_addr !== 16'd14400) begin n_bad++; $display("FAIL corner_rom_addr got %0d want 14400", rom_addr); end
        put(1'b0, 10'd0, 10'd0);
        n_cmp++;
        if (pix_valid_out !== 1'b0) begin n_bad++; $display("FAIL corner_early_valid got %b want 0", pix_valid_out); end
        put(1'b0, 10'd0, 10'd0);
        n_cmp++;
        if (outs !== {1'b1, 4'd7, 1'b1, 1'b1, 1'b1}) begin n_bad++; $display("FAIL corner_outs got %h want bf", outs); end
        drain();
    endtask

    task automatic test_mid_square();
        board_mem[19] = 4'd12; rom_const = 4'd7;
        put(1'b1, 10'd270, 10'd125);
        n_cmp++;
        if (board_addr !== 6'd19) begin n_bad++; $display("FAIL mid_board_addr got %0d want 19", board_addr); end
        put(1'b0, 10'd0, 10'd0);
        n_cmp++;
        if (rom_addr !== 16'd39910) begin n_bad++; $display("FAIL mid_rom_addr got %0d want 39910", rom_addr); end
        put(1'b0, 10'd0, 10'd0);
        put(1'b0, 10'd0, 10'd0);
        n_cmp++;
        if (outs !== {1'b1, 4'd1, 1'b1, 1'b0, 1'b1}) begin n_bad++; $display("FAIL mid_outs got %h want 8d", outs); end
        drain();
    endtask

    task automatic test_boundaries();
        logic [9:0] bx [4];
        logic [9:0] by [4];
        bx = '{10'd79, 10'd560, 10'd1000, 10'd100};
        by = '{10'd10, 10'd10, 10'd10, 10'd480};
        board_mem[0] = 4'd5; rom_const = 4'd9;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, bx[i], by[i]);
            n_cmp++;
            if (board_addr !== 6'd0) begin n_bad++; $display("FAIL outside%0d_board_addr got %0d want 0", i, board_addr); end
            put(1'b0, 10'd0, 10'd0);
            n_cmp++;
            if (rom_addr !== 16'd0) begin n_bad++; $display("FAIL outside%0d_rom_addr got %0d want 0", i, rom_addr); end
            put(1'b0, 10'd0, 10'd0);
            put(1'b0, 10'd0, 10'd0);
            n_cmp++;
            if (outs !== 8'h80) begin n_bad++; $display("FAIL outside%0d_outs got %h want 80", i, outs); end
        end
        board_mem[63] = 4'd1; rom_const = 4'd7;
        put(1'b1, 10'd559, 10'd479);
        n_cmp++;
        if (board_addr !== 6'd63) begin n_bad++; $display("FAIL last_board_addr got %0d want 63", board_addr); end
        put(1'b0, 10'd0, 10'd0);
        n_cmp++;
        if (rom_addr !== 16'd3599) begin n_bad++; $display("FAIL last_rom_addr got %0d want 3599", rom_addr); end
        put(1'b0, 10'd0, 10'd0);
        put(1'b0, 10'd0, 10'd0);
        n_cmp++;
        if (outs !== {1'b1, 4'd8, 1'b1, 1'b1, 1'b1}) begin n_bad++; $display("FAIL last_outs got %h want c7", outs); end
        drain();
    endtask

    task automatic test_empty_codes();
        logic [3:0] codes [3];
        codes = '{4'd0, 4'd13, 4'd15};
        rom_const = 4'd9;
        for (int i = 0; i < 3; i++) begin
            board_mem[1] = codes[i];
            put(1'b1, 10'd140, 10'd0);
            n_cmp++;
            if (board_addr !== 6'd1) begin n_bad++; $display("FAIL empty%0d_board_addr got %0d want 1", codes[i], board_addr); end
            put(1'b0, 10'd0, 10'd0);
            n_cmp++;
            if (rom_addr !== 16'd0) begin n_bad++; $display("FAIL empty%0d_rom_addr got %0d want 0", codes[i], rom_addr); end
            put(1'b0, 10'd0, 10'd0);
            put(1'b0, 10'd0, 10'd0);
            n_cmp++;
            if (outs !== 8'h81) begin n_bad++; $display("FAIL empty%0d_outs got %h want 81", codes[i], outs); end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [9:0]  px [4];
        logic [9:0]  py [4];
        logic [15:0] exp_rom [4];
        logic [7:0]  exp_out [4];
        px = '{10'd80, 10'd270, 10'd79, 10'd559};
        py = '{10'd0, 10'd125, 10'd10, 10'd479};
        exp_rom = '{16'd14400, 16'd39910, 16'd0, 16'd3599};
        exp_out = '{8'hbf, 8'h8d, 8'h80, 8'hc7};
        board_mem[0] = 4'd5; board_mem[19] = 4'd12; board_mem[63] = 4'd1; rom_const = 4'd7;
        for (int j = 0; j < 8; j++) begin
            @(negedge Clk);
            #1;
            if (j >= 1 && j <= 4) begin
                n_cmp++;
                if (rom_addr !== exp_rom[j-1]) begin
                    n_bad++; $display("FAIL b2b%0d_rom_addr got %0d want %0d", j - 1, rom_addr, exp_rom[j-1]);
                end
            end
            n_cmp++;
            if (j >= 3 && j <= 6) begin
                if (outs !== exp_out[j-3]) begin
                    n_bad++; $display("FAIL b2b%0d_outs got %h want %h", j - 3, outs, exp_out[j-3]);
                end
            end else if (pix_valid_out !== 1'b0) begin
                n_bad++; $display("FAIL b2b_bubble%0d_valid got %b want 0", j, pix_valid_out);
            end
            pix_valid = (j < 4);
            DrawX = (j < 4) ? px[j] : 10'd0;
            DrawY = (j < 4) ? py[j] : 10'd0;
        end
        drain();
    endtask

    task automatic test_mid_reset();
        for (int j = 0; j < 20; j++) begin
            put(1'b1, 10'(80 + j * 20), 10'd0);
            if (j >= 3 && j <= 9) begin
                n_cmp++;
                if (pix_valid_out !== 1'b1) begin n_bad++; $display("FAIL stream%0d_valid got %b want 1", j, pix_valid_out); end
            end
            if (j == 9) begin
                Reset = 1'b1;
                #1;
                n_cmp++;
                if (outs !== 8'h00) begin n_bad++; $display("FAIL midreset_outs got %h want 00", outs); end
            end
        end
        @(negedge Clk);
        pix_valid = 1'b0;
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            put(1'b0, 10'd0, 10'd0);
            n_cmp++;
            if (pix_valid_out !== 1'b0) begin n_bad++; $display("FAIL post_reset%0d_valid got %b want 0", i, pix_valid_out); end
        end
    endtask

`ifdef BOARD_FLIP_EN
    task automatic test_flip();
        board_mem[63] = 4'd2; rom_const = 4'd7;
        flip = 1'b1;
        put(1'b1, 10'd80, 10'd0);
        n_cmp++;
        if (board_addr !== 6'd63) begin n_bad++; $display("FAIL flip_board_addr got %0d want 63", board_addr); end
        put(1'b0, 10'd0, 10'd0);
        n_cmp++;
        if (rom_addr !== 16'd3600) begin n_bad++; $display("FAIL flip_rom_addr got %0d want 3600", rom_addr); end
        put(1'b0, 10'd0, 10'd0);
        put(1'b0, 10'd0, 10'd0);
        n_cmp++;
        if (outs !== {1'b1, 4'd7, 1'b1, 1'b1, 1'b1}) begin n_bad++; $display("FAIL flip_outs got %h want bf", outs); end
        put(1'b1, 10'd559, 10'd479);
        n_cmp++;
        if (board_addr !== 6'd0) begin n_bad++; $display("FAIL flip_last_board_addr got %0d want 0", board_addr); end
        flip = 1'b0;
        drain();
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) board_mem[i] = 4'd0;
        test_reset();
        test_corner_square();
        test_mid_square();
        test_boundaries();
        test_empty_codes();
        test_back_to_back();
        test_mid_reset();
`ifdef BOARD_FLIP_EN
        test_flip();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/piece_sprite_fetch.md
Name: piece_sprite_fetch

Overview:
Pixel-pipeline stage directly upstream of the per-piece palette lookup. It takes the VGA raster coordinate and finds the board square under it. It reads that square's piece code from board RAM, then reads the 4-bit palette index from the unified piece sprite ROM. The index, with per-pixel qualifiers, goes to the palette and the downstream compositor.

Parameters:
BOARD_X0, 80, left pixel column of the board on the 640x480 display
BOARD_Y0, 0, top pixel row of the board
SQ_SIZE, 60, square edge in pixels; sprites are SQ_SIZE x SQ_SIZE
ROM_AW, 16, sprite ROM address width; 12 sprites x 3600 = 43200 entries

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
pix_valid  in  1  DrawX/DrawY valid this cycle
DrawX  in  10  raster column
DrawY  in  10  raster row
board_addr  out  6  board RAM read address, row*8+col; combinational from stage-0 inputs
board_data  in  4  piece code, 0 = empty, 1..12 = piece; synchronous RAM, 1-cycle latency
rom_addr  out  ROM_AW  sprite ROM read address; combinational from stage-1 registers
rom_data  in  4  palette index; synchronous ROM, 1-cycle latency
pix_valid_out  out  1  outputs below are valid
pal_index  out  4  palette index to the palette stage
piece_present  out  1  square holds a piece
square_light  out  1  light square
in_board  out  1  pixel lies inside the board

Behaviour:
- Reset (async): every pipeline register and every output goes to 0 immediately. No pending pixel survives a mid-stream reset. The first valid output comes 3 cycles after the first post-reset pix_valid.
- Stage 0 (cycle N, combinational):
  - x_rel = DrawX - BOARD_X0, y_rel = DrawY - BOARD_Y0.
  - in_board = DrawX in [BOARD_X0, BOARD_X0+8*SQ_SIZE-1] and DrawY in [BOARD_Y0, BOARD_Y0+8*SQ_SIZE-1].
  - col = count of k in 1..7 with x_rel >= k*SQ_SIZE; row likewise from y_rel. Use a comparator chain; no divider.
  - x_in = x_rel - col*SQ_SIZE, y_in = y_rel - row*SQ_SIZE, both 6 bits.
  - board_addr = row*8+col when in_board, else 0.
- Stage 1 (N+1): registers valid, in_board, x_in, y_in, light = ~(row^col)[0] (row 0 col 0 is light).
  - rom_addr = (board_data-1)*SQ_SIZE*SQ_SIZE + y_in*SQ_SIZE + x_in when board_data in 1..12 and in_board; else 0.
  - Computed at full ROM_AW width, no truncation for legal codes.
  - Codes 13..15 count as empty.
- Stage 2 (N+2): registers valid, in_board, light, present = (board_data in 1..12) & in_board.
- Output register (N+3):
  - pal_index = rom_data if present, else 0.
  - piece_present, square_light, in_board and pix_valid_out are copies of stage 2.
  - square_light is 0 when outside the board.
- Total latency 3 cycles. Throughput is 1 pixel/cycle with no backpressure; bubbles (pix_valid=0) propagate as pix_valid_out=0, and their other outputs are 0.
- Boundaries:
  - DrawX = BOARD_X0-1 or BOARD_X0+480 gives in_board=0.
  - Last board pixel (559,479) gives col7/row7, x_in=y_in=59.
  - DrawX/DrawY beyond 639/479 count as outside the board.

Optional Feature:
BOARD_FLIP_EN:
- Defined: adds input port flip (1 bit). When flip=1, board_addr = 63 - (row*8+col), a 180-degree view rotation for the black side.
  - Sprite pixels are not mirrored.
  - square_light is unchanged, because parity is preserved.
  - flip is sampled in stage 0, alongside its pixel.
- Undefined: no flip port; board_addr is always row*8+col.

Test Plan:
1. Hold Reset, drive pix_valid=1 -> all outputs 0. Release Reset, first pixel at N -> pix_valid_out=1 at N+3, not earlier.
2. DrawX=80, DrawY=0, board_data=5, rom_data=7 -> board_addr=0 at N; rom_addr=14400 at N+1; at N+3 pal_index=7, piece_present=1, square_light=1, in_board=1.
3. DrawX=270, DrawY=125, board_data=12 -> board_addr=19; rom_addr=39910; square_light=0.
4. DrawX=79 then DrawX=560 (DrawY=10) -> in_board=0, pal_index=0, piece_present=0, board_addr=0. DrawX=559, DrawY=479 -> board_addr=63, x_in=59, y_in=59.
5. Empty square (board_data=0, rom_data=9) -> pal_index=0, piece_present=0, rom_addr=0. Codes 13 and 15 behave identically.
6. Stream 20 consecutive pixels, then assert Reset at the 10th -> pix_valid_out drops the same cycle and no stale pixel emerges after release. With BOARD_FLIP_EN and flip=1, DrawX=80, DrawY=0 -> board_addr=63.
